// File: rtl/uart_mul_pkg.sv
// Shared types and constants for the UART-fronted multiplier sequencer.
// Optional checksum support is enabled with `define UART_MUL_CTRL_CHECKSUM_EN.
package uart_mul_pkg;

`ifdef UART_MUL_CTRL_CHECKSUM_EN
  typedef enum logic [3:0] {
    StIdle,
    StOpcode,
    StOpA,
    StOpB,
    StCsum,
    StIssue,
    StWait,
    StTxHdr,
    StTxData,
    StTxCsum,
    StTxErr
  } ctrl_state_e;
`else
  typedef enum logic [3:0] {
    StIdle,
    StOpcode,
    StOpA,
    StOpB,
    StIssue,
    StWait,
    StTxHdr,
    StTxData
  } ctrl_state_e;
`endif

  localparam logic [7:0] ReqHeader = 8'hA5;
  localparam logic [7:0] RspHeader = 8'h5A;
  localparam logic [7:0] ErrByte   = 8'hE1;

  // Opcode bit positions
  localparam int unsigned OpcSignedABit  = 0;
  localparam int unsigned OpcSignedBBit  = 1;
  localparam int unsigned OpcGetsHighBit = 2;

  typedef struct packed {
    logic [4:0] unused;
    logic       gets_high;
    logic       signed_b;
    logic       signed_a;
  } opcode_t;

  // Byte idx of a word, MSB first (idx 0 = bits 31:24).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // States in which the request byte stream is accepted.
  function automatic logic is_rx_state(input ctrl_state_e s);
`ifdef UART_MUL_CTRL_CHECKSUM_EN
    return (s == StIdle) || (s == StOpcode) || (s == StOpA) || (s == StOpB) || (s == StCsum);
`else
    return (s == StIdle) || (s == StOpcode) || (s == StOpA) || (s == StOpB);
`endif
  endfunction

endpackage

// File: rtl/uart_mul_timeout.sv
// Inter-byte idle counter: counts running cycles since the last clear and flags
// expiry on the TimeoutCycles-th idle cycle. TimeoutCycles = 0 never expires.
module uart_mul_timeout #(
  parameter int unsigned TimeoutCycles = 1_200_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (TimeoutCycles != 0) && run_i && (cnt_q == Limit);

  // Next count: reload on clear or when idle, otherwise count up and hold at expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_mul_ctrl.sv
// Framed-command sequencer between a UART byte stream and an iterative multiplier.
// Request: A5, opcode, A (4 bytes MSB first), B (4 bytes MSB first).
// Response: 5A, R (4 bytes MSB first).
// `define UART_MUL_CTRL_CHECKSUM_EN adds a trailing XOR byte to both frames and
// an E1 error response on a request checksum mismatch.
module uart_mul_ctrl
  import uart_mul_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1_200_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] mul_opA_o,
  output logic [31:0] mul_opB_o,
  output logic        mul_signed_opA_o,
  output logic        mul_signed_opB_o,
  output logic        mul_gets_high_o,
  output logic        mul_v_o,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_result_i,
  input  logic        mul_v_i,
  output logic        mul_yumi_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        frame_err_o
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  opc_q, opc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_ready_q, rx_ready_d;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic rx_fire;
  logic tmo_clear;
  logic tmo_run;
  logic tmo_expired;

  assign rx_fire = rx_valid_i && rx_ready_o;

  assign rx_ready_o       = rx_ready_q;
  assign mul_opA_o        = opa_q;
  assign mul_opB_o        = opb_q;
  assign mul_signed_opA_o = opc_q[OpcSignedABit];
  assign mul_signed_opB_o = opc_q[OpcSignedBBit];
  assign mul_gets_high_o  = opc_q[OpcGetsHighBit];
  assign mul_v_o          = (state_q == StIssue);
  assign busy_o           = (state_q != StIdle);
  assign frame_err_o      = frame_err_q;

  // Timeout restarts on every accepted byte and on every state change.
  assign tmo_clear = rx_fire || (state_d != state_q);
  assign tmo_run   = is_rx_state(state_q) && (state_q != StIdle);

  uart_mul_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (tmo_clear),
    .run_i    (tmo_run),
    .expired_o(tmo_expired)
  );

  // Frame parsing, multiplier handshake and response sequencing
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    opc_d       = opc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    frame_err_d = 1'b0;
    mul_yumi_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        idx_d = 2'd0;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
        csum_d = 8'h00;
`endif
        if (rx_fire && (rx_data_i == ReqHeader)) begin
          state_d = StOpcode;
        end
      end
      StOpcode: begin
        if (rx_fire) begin
          opc_d   = rx_data_i[2:0];
          state_d = StOpA;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data_i;
`endif
        end else if (tmo_expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end
      end
      StOpA: begin
        if (rx_fire) begin
          opa_d = {opa_q[23:0], rx_data_i};
          idx_d = idx_q + 2'd1;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
          csum_d = csum_q ^ rx_data_i;
`endif
          if (idx_q == 2'd3) begin
            state_d = StOpB;
          end
        end else if (tmo_expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end
      end
      StOpB: begin
        if (rx_fire) begin
          opb_d = {opb_q[23:0], rx_data_i};
          idx_d = idx_q + 2'd1;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
          csum_d = csum_q ^ rx_data_i;
          if (idx_q == 2'd3) begin
            state_d = StCsum;
          end
`else
          if (idx_q == 2'd3) begin
            state_d = StIssue;
          end
`endif
        end else if (tmo_expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end
      end
`ifdef UART_MUL_CTRL_CHECKSUM_EN
      StCsum: begin
        if (rx_fire) begin
          if (rx_data_i == csum_q) begin
            state_d = StIssue;
          end else begin
            state_d     = StTxErr;
            frame_err_d = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end
      end
`endif
      StIssue: begin
        if (mul_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mul_v_i) begin
          mul_yumi_o = 1'b1;
          res_d      = mul_result_i;
          state_d    = StTxHdr;
        end
      end
      StTxHdr: begin
        tx_valid_o = 1'b1;
        tx_data_o  = RspHeader;
        if (tx_ready_i) begin
          state_d = StTxData;
        end
      end
      StTxData: begin
        // idx_q wrapped back to 0 after the last operand byte
        tx_valid_o = 1'b1;
        tx_data_o  = word_byte(res_q, idx_q);
        if (tx_ready_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef UART_MUL_CTRL_CHECKSUM_EN
            state_d = StTxCsum;
`else
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef UART_MUL_CTRL_CHECKSUM_EN
      StTxCsum: begin
        tx_valid_o = 1'b1;
        tx_data_o  = xor_bytes(res_q);
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
      StTxErr: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ErrByte;
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Registered so rx_ready_o stays low while reset is asserted
    rx_ready_d = is_rx_state(state_d);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      opc_q       <= 3'd0;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      res_q       <= 32'd0;
      frame_err_q <= 1'b0;
      rx_ready_q  <= 1'b0;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      opc_q       <= opc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      frame_err_q <= frame_err_d;
      rx_ready_q  <= rx_ready_d;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mul_ctrl.sv
// Self-checking bench for uart_mul_ctrl: randomized frames, a behavioural
// multiplier, and a frame-level reference for the expected response bytes.
module tb_uart_mul_ctrl;

  localparam int unsigned Tmo = 16;
`ifdef UART_MUL_CTRL_CHECKSUM_EN
  localparam int RspLen = 6;
`else
  localparam int RspLen = 5;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [31:0] mul_opA_o, mul_opB_o;
  logic        mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_o;
  logic        mul_v_o;
  logic        mul_ready_i;
  logic [31:0] mul_result_i;
  logic        mul_v_i;
  logic        mul_yumi_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        frame_err_o;

  always #5 clk_i = ~clk_i;

  uart_mul_ctrl #(
    .TimeoutCycles(Tmo)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .mul_opA_o       (mul_opA_o),
    .mul_opB_o       (mul_opB_o),
    .mul_signed_opA_o(mul_signed_opA_o),
    .mul_signed_opB_o(mul_signed_opB_o),
    .mul_gets_high_o (mul_gets_high_o),
    .mul_v_o         (mul_v_o),
    .mul_ready_i     (mul_ready_i),
    .mul_result_i    (mul_result_i),
    .mul_v_i         (mul_v_i),
    .mul_yumi_o      (mul_yumi_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .busy_o          (busy_o),
    .frame_err_o     (frame_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic meaning of the opcode flags: extend each operand, multiply, pick a word.
  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input logic hi);
    longint va, vb, p;
    va = sa ? longint'($signed(a)) : longint'({32'h0, a});
    vb = sb ? longint'($signed(b)) : longint'({32'h0, b});
    p  = va * vb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int err_pulses = 0;
  always @(negedge clk_i) if (frame_err_o) err_pulses++;

  // TX sink: optional random back-pressure, records accepted bytes and checks hold stability
  bit          tx_rand = 1'b0;
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];
  int          tx_unstable = 0;
  initial begin : tx_sink
    logic       prev_v, prev_acc;
    logic [7:0] prev_d;
    tx_ready_i = 1'b0;
    prev_v = 1'b0;
    prev_acc = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        tx_ready_i = 1'b0;
        prev_v = 1'b0;
      end else begin
        tx_ready_i = tx_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (prev_v && !prev_acc && (!tx_valid_o || tx_data_o != prev_d)) tx_unstable++;
        prev_acc = tx_valid_o && tx_ready_i;
        prev_v = tx_valid_o;
        prev_d = tx_data_o;
        if (prev_acc) begin
          tx_q.push_back(tx_data_o);
          tx_cyc.push_back(cyc);
        end
      end
    end
  end

  // Behavioural multiplier: delayed ready, delayed product, operands checked for stability
  int          rdy_delay = 0;
  int          prod_delay = 0;
  int          n_issue = 0;
  int          op_unstable = 0;
  logic [31:0] cap_a = '0, cap_b = '0;
  logic [2:0]  cap_f = '0;
  initial begin : mul_model
    int          rcnt, pcnt;
    bit          iss_hs, ret_hs, pend;
    logic [31:0] prod;
    mul_ready_i = 1'b0;
    mul_v_i = 1'b0;
    mul_result_i = '0;
    rcnt = 0; pcnt = 0; iss_hs = 0; ret_hs = 0; pend = 0; prod = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        mul_ready_i = 1'b0;
        mul_v_i = 1'b0;
        iss_hs = 0; ret_hs = 0; pend = 0; rcnt = 0;
      end else begin
        if (iss_hs) begin mul_ready_i = 1'b0; pend = 1; iss_hs = 0; end
        if (ret_hs) begin mul_v_i = 1'b0; ret_hs = 0; end
        if ((pend || mul_v_i) && ({mul_opA_o, mul_opB_o, mul_gets_high_o, mul_signed_opB_o,
             mul_signed_opA_o} != {cap_a, cap_b, cap_f})) op_unstable++;
        if (pend) begin
          if (pcnt == 0) begin mul_v_i = 1'b1; mul_result_i = prod; pend = 0; end
          else pcnt--;
        end
        if (mul_v_o && !mul_ready_i) begin
          if (rcnt >= rdy_delay) mul_ready_i = 1'b1;
          else rcnt++;
        end
        #1;
        if (mul_v_o && mul_ready_i) begin
          iss_hs = 1; rcnt = 0; n_issue++;
          cap_a = mul_opA_o; cap_b = mul_opB_o;
          cap_f = {mul_gets_high_o, mul_signed_opB_o, mul_signed_opA_o};
          prod = mul_ref(cap_a, cap_b, cap_f[0], cap_f[1], cap_f[2]);
          pcnt = prod_delay;
        end
        if (mul_v_i && mul_yumi_o) ret_hs = 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i = b;
    while (!rx_ready_o && guard < 1000) begin @(negedge clk_i); guard++; end
    if (guard >= 1000) check_eq("rx_accept_bound", 0, 1);
    @(posedge clk_i);
    #1 rx_valid_i = 1'b0;
  endtask

  // Send one request frame and check the full response against the reference.
  task automatic run_frame(input string tag, input logic [7:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input int max_gap, input int long_gap_at);
    logic [7:0]  req[$];
    logic [7:0]  exp[$];
    logic [31:0] r;
    int          issues0, err0, viol, guard, g;
    req = '{8'hA5, opc, a[31:24], a[23:16], a[15:8], a[7:0], b[31:24], b[23:16], b[15:8], b[7:0]};
    r = mul_ref(a, b, opc[0], opc[1], opc[2]);
    exp = '{8'h5A, r[31:24], r[23:16], r[15:8], r[7:0]};
`ifdef UART_MUL_CTRL_CHECKSUM_EN
    req.push_back(opc ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^
                  b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0]);
    exp.push_back(r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0]);
`endif
    tx_q.delete();
    tx_cyc.delete();
    issues0 = n_issue;
    err0 = err_pulses;
    tx_unstable = 0;
    op_unstable = 0;
    for (int i = 0; i < req.size(); i++) begin
      g = (i == long_gap_at) ? int'(Tmo) - 1 : $urandom_range(0, max_gap);
      repeat (g) @(negedge clk_i);
      send_byte(req[i]);
    end
    viol = 0;
    guard = 0;
    while (tx_q.size() < RspLen && guard < 2000) begin
      @(negedge clk_i);
      if (rx_ready_o && tx_q.size() < RspLen) viol++;
      guard++;
    end
    check_eq({tag, "_rsp_len"}, tx_q.size(), RspLen);
    for (int i = 0; i < RspLen && i < tx_q.size(); i++)
      check_eq($sformatf("%s_rsp_byte%0d", tag, i), tx_q[i], exp[i]);
    check_eq({tag, "_issues"}, n_issue - issues0, 1);
    check_eq({tag, "_opA"}, cap_a, a);
    check_eq({tag, "_opB"}, cap_b, b);
    check_eq({tag, "_flags"}, cap_f, opc[2:0]);
    check_eq({tag, "_op_stable"}, op_unstable, 0);
    check_eq({tag, "_tx_stable"}, tx_unstable, 0);
    check_eq({tag, "_rx_ready_low"}, viol, 0);
    check_eq({tag, "_no_err"}, err_pulses - err0, 0);
    if (!tx_rand && tx_cyc.size() == RspLen)
      check_eq({tag, "_back_to_back"}, tx_cyc[RspLen-1] - tx_cyc[0], RspLen - 1);
    @(negedge clk_i);
    check_eq({tag, "_rx_ready_after"}, rx_ready_o, 1);
    check_eq({tag, "_idle_after"}, busy_o, 0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int issues0, err0;
    // Reset state
    repeat (3) @(negedge clk_i);
    check_eq("reset_outputs", {rx_ready_o, mul_v_o, mul_yumi_o, tx_valid_o, busy_o,
             frame_err_o, mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_o}, 0);
    check_eq("reset_data", {tx_data_o, mul_opA_o, mul_opB_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("rx_ready_after_reset", rx_ready_o, 1);

    // Basic unsigned low-word product with an instant multiplier
    tx_rand = 0; rdy_delay = 0; prod_delay = 0;
    run_frame("basic", 8'h00, 32'h3, 32'h7, 0, -1);

    // All flags set: signed x signed, high word
    run_frame("signed_hi", 8'h07, 32'hFFFF_FFFE, 32'h0000_0003, 0, -1);

    // Leading garbage is dropped without error
    err0 = err_pulses;
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk_i);
    check_eq("garbage_idle", busy_o, 0);
    run_frame("after_garbage", 8'hF8, 32'h1234_5678, 32'h9ABC_DEF0, 1, -1);
    check_eq("garbage_no_err", err_pulses - err0, 0);

    // Inter-byte timeout mid-frame
    issues0 = n_issue;
    err0 = err_pulses;
    tx_q.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hAA);
    @(negedge clk_i);
    check_eq("tmo_busy_before", busy_o, 1);
    repeat (Tmo + 4) @(negedge clk_i);
    check_eq("tmo_err_pulses", err_pulses - err0, 1);
    check_eq("tmo_busy_after", busy_o, 0);
    check_eq("tmo_no_issue", n_issue - issues0, 0);
    check_eq("tmo_no_tx", tx_q.size(), 0);
    check_eq("tmo_rx_ready", rx_ready_o, 1);

    // A byte landing on the last idle cycle before expiry keeps the frame alive
    run_frame("byte_wins", 8'h03, 32'hDEAD_BEEF, 32'h0000_0101, 0, 5);

    // Back-pressure on TX and a slow multiplier accept
    tx_rand = 1; rdy_delay = 5; prod_delay = 3;
    run_frame("backpressure", 8'h05, 32'h8000_0001, 32'hFFFF_FFFF, 2, -1);

    // Reset mid-frame aborts cleanly
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_eq("midreset_state", {busy_o, rx_ready_o, mul_v_o, tx_valid_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("midreset_rx_ready", rx_ready_o, 1);

`ifdef UART_MUL_CTRL_CHECKSUM_EN
    // Bad request checksum: single error byte, no multiply
    issues0 = n_issue;
    err0 = err_pulses;
    tx_rand = 0;
    tx_q.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'h01);
    send_byte(8'h55);
    repeat (20) @(negedge clk_i);
    check_eq("csum_bad_len", tx_q.size(), 1);
    if (tx_q.size() > 0) check_eq("csum_bad_byte", tx_q[0], 8'hE1);
    check_eq("csum_bad_no_issue", n_issue - issues0, 0);
    check_eq("csum_bad_err", err_pulses - err0, 1);
`endif

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      tx_rand = ($urandom_range(0, 1) == 1);
      rdy_delay = $urandom_range(0, 6);
      prod_delay = $urandom_range(0, 8);
      run_frame($sformatf("rand%0d", k), 8'($urandom), rand_word(), rand_word(), 3, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
